stack_ctl: RTL

STACK_CTL -- requirements
Module: stack_ctl

---
 rtl/stack_ctl_pkg.sv | 17 +
 rtl/stack_mem.sv | 37 +++
 rtl/stack_ctl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/stack_ctl_pkg.sv
// rtl/stack_ctl_pkg.sv - shared state encoding and depth derivation for stack_ctl
//
// Contents:
//   state_t      - controller states: IDLE (accepting requests), REFILL (reloading dout)
//   stack_depth  - number of storage entries for a given address width
package stack_ctl_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    function automatic int stack_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/stack_mem.sv
// rtl/stack_mem.sv - stack storage array, combinational read, synchronous write
//
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write address (ADDR_WIDTH)
//   wdata  in   write data (WIDTH)
//   raddr  in   read address (ADDR_WIDTH)
//   rdata  out  read data, combinational on raddr (WIDTH)
module stack_mem
    import stack_ctl_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    localparam int DEPTH = stack_depth(ADDR_WIDTH);

    // No reset: contents survive rst_n so only the pointer state is cleared.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_ctl.sv
// rtl/stack_ctl.sv - LIFO stack controller with registered top-of-stack output
//
// Optional feature: define STACK_CTL_HWM_EN to add the hwm high-water-mark output.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   push     in   push request, taken only while ready
//   pop      in   pop request, taken only while ready
//   din      in   data to push (WIDTH)
//   clr_err  in   clears the sticky error flag
//   ready    out  requests accepted this cycle (state IDLE)
//   dout     out  registered top-of-stack, 0 when empty (WIDTH)
//   empty    out  depth == 0
//   full     out  depth == DEPTH
//   depth    out  entry count (ADDR_WIDTH+1)
//   err      out  sticky overflow/underflow flag
//   hwm      out  peak depth since reset (ADDR_WIDTH+1, STACK_CTL_HWM_EN only)
module stack_ctl
    import stack_ctl_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    input  logic                  clr_err,
    output logic                  ready,
    output logic [WIDTH-1:0]      dout,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   depth,
    output logic                  err
`ifdef STACK_CTL_HWM_EN
    ,
    output logic [ADDR_WIDTH:0]   hwm
`endif
);

    localparam int                DEPTH     = stack_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = DEPTH[ADDR_WIDTH:0];

    state_t                  state, state_n;
    logic [ADDR_WIDTH:0]     depth_n;
    logic [ADDR_WIDTH:0]     depth_m1;
    logic [WIDTH-1:0]        dout_n;
    logic                    err_set;

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [ADDR_WIDTH-1:0]   mem_raddr;
    logic [WIDTH-1:0]        mem_rdata;

    stack_mem #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (din),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    assign ready    = (state == IDLE);
    assign empty    = (depth == '0);
    assign full     = (depth == DEPTH_CNT);
    assign depth_m1 = depth - 1'b1;

    // In REFILL depth has already been decremented, so depth-1 addresses the new top.
    // When the stack became empty the read address wraps, but the value is discarded.
    assign mem_raddr = depth_m1[ADDR_WIDTH-1:0];

    always_comb begin
        state_n   = state;
        depth_n   = depth;
        dout_n    = dout;
        err_set   = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = depth[ADDR_WIDTH-1:0];

        case (state)
            IDLE: begin
                if (push && pop && !empty) begin
                    // Replace the top entry in place.
                    mem_we    = 1'b1;
                    mem_waddr = depth_m1[ADDR_WIDTH-1:0];
                    dout_n    = din;
                end else if (push) begin
                    // Covers push+pop on an empty stack, which behaves as a plain push.
                    if (full) begin
                        err_set = 1'b1;
                    end else begin
                        mem_we  = 1'b1;
                        dout_n  = din;
                        depth_n = depth + 1'b1;
                    end
                end else if (pop) begin
                    if (empty) begin
                        err_set = 1'b1;
                    end else begin
                        depth_n = depth_m1;
                        state_n = REFILL;
                    end
                end
            end
            REFILL: begin
                dout_n  = empty ? '0 : mem_rdata;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            depth <= '0;
            dout  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            depth <= depth_n;
            dout  <= dout_n;
            // A new error takes priority over a simultaneous clear.
            if (err_set) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end
        end
    end

`ifdef STACK_CTL_HWM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hwm <= '0;
        end else if (depth_n > hwm) begin
            hwm <= depth_n;
        end
    end
`endif

endmodule
